cloud_index_writer: RTL

Palette encoder and writer for the 160x120 cloud index layer. Accepts a raster stream of 24-bit RGB pixels over a valid/ready handshake and maps each pixel to the 4-bit cloud palette index. It writes the index into the cloud index memory at the matching raster address. It is the write side of the cloud layer: it produces the memory image that the display path reads back through the same five-entry palette.

---
 rtl/cloud_index_writer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/cloud_index_writer.sv
// cloud_index_writer: palette encoder and raster writer for the 160x120 cloud index layer.
// Each accepted RGB pixel is mapped to a 4-bit palette index. The index is written
// one cycle later at address row*WIDTH+col.
// Build option: define CLOUD_WR_NEAREST_EN to encode non-exact pixels to the nearest
// palette entry by L1 distance. When it is undefined, non-exact pixels encode to 0.
module cloud_index_writer #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120,
    parameter int ADDR_W = 15
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic              pix_valid,
    input  logic [23:0]       pix_rgb,
    output logic              pix_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [3:0]        wr_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] unmatched_cnt
);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(WIDTH * HEIGHT - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] unm_q, unm_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [3:0]        wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d;
    logic              pix_ready_q, pix_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              accept;
    logic              enc_exact;
    logic [3:0]        enc_idx;

    function automatic logic [23:0] pal_rgb(input int idx);
        case (idx)
            1:       return 24'hDAECF2;
            2:       return 24'h97C5E7;
            3:       return 24'hB0D4EF;
            4:       return 24'hC6E0F4;
            default: return 24'h000000;
        endcase
    endfunction

`ifdef CLOUD_WR_NEAREST_EN
    function automatic logic [9:0] dist10(input logic [23:0] a, input logic [23:0] b);
        logic [7:0] dr, dg, db;
        dr = (a[23:16] > b[23:16]) ? a[23:16] - b[23:16] : b[23:16] - a[23:16];
        dg = (a[15:8]  > b[15:8])  ? a[15:8]  - b[15:8]  : b[15:8]  - a[15:8];
        db = (a[7:0]   > b[7:0])   ? a[7:0]   - b[7:0]   : b[7:0]   - a[7:0];
        return 10'(dr) + 10'(dg) + 10'(db);
    endfunction

    logic [9:0] best_dist;
    logic [9:0] cur_dist;
    logic [3:0] near_idx;
`endif

    // Palette encoder: exact match first, otherwise the fallback index for this build.
    always_comb begin
        enc_exact = 1'b0;
        enc_idx   = 4'd0;
        for (int i = 0; i < 5; i++) begin
            if (!enc_exact && pix_rgb == pal_rgb(i)) begin
                enc_exact = 1'b1;
                enc_idx   = 4'(i);
            end
        end
`ifdef CLOUD_WR_NEAREST_EN
        // Strict less-than while scanning upward makes ties resolve to the lowest index.
        best_dist = 10'h3FF;
        near_idx  = 4'd0;
        cur_dist  = 10'd0;
        for (int i = 0; i < 5; i++) begin
            cur_dist = dist10(pix_rgb, pal_rgb(i));
            if (cur_dist < best_dist) begin
                best_dist = cur_dist;
                near_idx  = 4'(i);
            end
        end
        if (!enc_exact) enc_idx = near_idx;
`endif
    end

    // Next-state and next-output logic. The outputs are derived from the next state,
    // so every port comes straight from a flop.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        unm_d     = unm_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        accept    = pix_valid && pix_ready_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    unm_d   = '0;
                end
            end
            LOAD: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q;
                    wr_data_d = enc_idx;
                    cnt_d     = cnt_q + ADDR_W'(1);
                    if (!enc_exact) unm_d = unm_q + ADDR_W'(1);
                    if (cnt_q == LAST_PIX) state_d = FLUSH;
                end
            end
            FLUSH:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        pix_ready_d = (state_d == LOAD);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    // State and registered outputs. An asynchronous reset drops any pending write.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            unm_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 4'd0;
            pix_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            unm_q       <= unm_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            pix_ready_q <= pix_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign pix_ready     = pix_ready_q;
    assign wr_en         = wr_en_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign unmatched_cnt = unm_q;

endmodule
